// File: rtl/io_write_buffer_if.sv
// io_write_buffer_if: CPU-side and controller-side buses of the posted-write buffer.
// The slave modport is the buffer itself; master is whatever drives the CPU and controller.
interface io_write_buffer_if #(
    parameter int AW = 19
);
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_a;
    logic [3:0]    cpu_be;
    logic [31:0]   cpu_di;
    logic [31:0]   cpu_q;
    logic          cpu_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_a;
    logic [3:0]    mem_be;
    logic [31:0]   mem_di;
    logic [31:0]   mem_q;
    logic          mem_ready;
    modport slave (
        input  cpu_rd, cpu_wr, cpu_a, cpu_be, cpu_di, mem_q, mem_ready,
        output cpu_q, cpu_ready, mem_rd, mem_wr, mem_a, mem_be, mem_di
    );
    modport master (
        output cpu_rd, cpu_wr, cpu_a, cpu_be, cpu_di, mem_q, mem_ready,
        input  cpu_q, cpu_ready, mem_rd, mem_wr, mem_a, mem_be, mem_di
    );
endinterface

// File: rtl/io_write_buffer.sv
// io_write_buffer: posted-write FIFO in front of the SRAM RMW controller.
// Writes are acked once queued and drain in order; reads wait for a full drain.
module io_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int AW       = 19,
    parameter bit COALESCE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    io_write_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0] wb_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic [1:0] {C_IDLE, C_ACK, C_RD} c_state_e;
    typedef enum logic {M_IDLE, M_BUSY} m_state_e;
    c_state_e c_q, c_d;
    m_state_e m_q, m_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, last;
    logic [PW:0]   count_q, count_d;
    logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [3:0]    mem_be_q, mem_be_d, mrg_be;
    logic [31:0]   mem_di_q, mem_di_d, cpu_q_q, cpu_q_d, mrg_data;
    logic          hit, push, merge, pop, done, mrg_head;
    assign last     = tail_q - PW'(1);
    assign hit      = COALESCE && count_q != '0 && addr_q[last] == bus.cpu_a &&
                      !(count_q == (PW+1)'(1) && m_q == M_BUSY && mem_wr_q);
    assign push     = c_q == C_IDLE && bus.cpu_wr && !hit && count_q != FULL;
    assign merge    = c_q == C_IDLE && bus.cpu_wr && hit;
    assign done     = m_q == M_BUSY && bus.mem_ready;
    assign pop      = done && mem_wr_q;
    assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // A merge into a sole idle entry coincides with its issue, so the issue takes the merged bytes
    assign mrg_head = merge && last == head_q;
    always_comb begin
        mrg_be   = be_q[last] | bus.cpu_be;
        mrg_data = data_q[last];
        for (int k = 0; k < 4; k++)
            if (bus.cpu_be[k]) mrg_data[8*k +: 8] = bus.cpu_di[8*k +: 8];
    end
    always_comb begin
        c_d      = c_q;
        m_d      = m_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        mem_a_d  = mem_a_q;
        mem_be_d = mem_be_q;
        mem_di_d = mem_di_q;
        cpu_q_d  = cpu_q_q;
        case (c_q)
            C_IDLE:  c_d = bus.cpu_wr ? ((push || merge) ? C_ACK : C_IDLE) : (bus.cpu_rd ? C_RD : C_IDLE);
            C_ACK:   c_d = C_IDLE;
            default: if (done && mem_rd_q) begin
                c_d     = C_ACK;
                cpu_q_d = bus.mem_q;
            end
        endcase
        if (m_q == M_IDLE && count_q != '0) begin
            m_d      = M_BUSY;
            mem_wr_d = 1'b1;
            mem_a_d  = addr_q[head_q];
            mem_be_d = mrg_head ? mrg_be : be_q[head_q];
            mem_di_d = mrg_head ? mrg_data : data_q[head_q];
        end else if (m_q == M_IDLE && c_q == C_RD) begin
            m_d      = M_BUSY;
            mem_rd_d = 1'b1;
            mem_a_d  = bus.cpu_a;
            mem_be_d = 4'hf;
        end else if (done) begin
            m_d      = M_IDLE;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q      <= C_IDLE;
            m_q      <= M_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_a_q  <= '0;
            mem_be_q <= '0;
            mem_di_q <= '0;
            cpu_q_q  <= '0;
        end else begin
            c_q      <= c_d;
            m_q      <= m_d;
            head_q   <= pop ? head_q + PW'(1) : head_q;
            tail_q   <= push ? tail_q + PW'(1) : tail_q;
            count_q  <= count_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            mem_a_q  <= mem_a_d;
            mem_be_q <= mem_be_d;
            mem_di_q <= mem_di_d;
            cpu_q_q  <= cpu_q_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.cpu_a;
            be_q[tail_q]   <= bus.cpu_be;
            data_q[tail_q] <= bus.cpu_di;
        end else if (merge) begin
            be_q[last]   <= mrg_be;
            data_q[last] <= mrg_data;
        end
    end
    assign bus.cpu_ready = c_q == C_ACK;
    assign bus.cpu_q     = cpu_q_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_di    = mem_di_q;
    assign wb_count_o    = count_q;
endmodule

// File: tb/tb_io_write_buffer.sv
// tb_io_write_buffer: scoreboard bench; CPU ops queue expected acks, a monitor pops on cpu_ready,
// and a behavioural SRAM image (byte-masked writes in CPU order) predicts every read.
module tb_io_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 19;
    typedef struct packed { logic rd; logic [31:0] data; } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH):0] wb_count;
    io_write_buffer_if #(.AW(AW)) b ();
    io_write_buffer #(.DEPTH(DEPTH), .AW(AW), .COALESCE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(b), .wb_count_o(wb_count));
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0, ready_cyc = 0, mr_cyc = 0;
    int kick_req = 0, kick_done = 0, lat = 0;
    bit hold = 1'b1, prev_ready = 1'b0;
    logic [31:0] ref_mem [32];
    logic [31:0] sram [32];
    exp_t exp_q [$];
    logic [AW-1:0] wr_log [$];
    logic [3:0]  last_be = '0;
    logic [31:0] last_di = '0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask
    // SRAM controller model: random latency, or stalled under hold until kicked
    initial begin
        b.mem_ready = 1'b0;
        b.mem_q = '0;
        for (int i = 0; i < 32; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        forever begin
            @(posedge clk); #1;
            if (b.mem_ready) b.mem_ready = 1'b0;
            else if ((b.mem_wr || b.mem_rd) && (hold ? kick_req != kick_done : lat == 0)) begin
                kick_done = kick_req;
                if (b.mem_wr) begin
                    for (int k = 0; k < 4; k++)
                        if (b.mem_be[k]) sram[b.mem_a[4:0]][8*k +: 8] = b.mem_di[8*k +: 8];
                    wr_log.push_back(b.mem_a);
                    last_be = b.mem_be;
                    last_di = b.mem_di;
                end else b.mem_q = sram[b.mem_a[4:0]];
                b.mem_ready = 1'b1;
                lat = $urandom_range(0, 3);
            end else if ((b.mem_wr || b.mem_rd) && !hold && lat > 0) lat--;
        end
    end
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b.cpu_ready) begin
                ready_cyc = cyc;
                chk("ready_single_pulse", 32'(prev_ready), 0);
                chk("ready_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.rd) chk("read_data", b.cpu_q, e.data);
                end
            end
            prev_ready = b.cpu_ready;
            if (b.mem_rd) chk("rd_only_when_drained", {28'b0, wb_count, b.mem_wr}, 0);
        end
    end
    task automatic expect_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_q.push_back('{rd: 1'b0, data: 32'h0});
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[a[4:0]][8*k +: 8] = d[8*k +: 8];
    endtask
    task automatic wait_ready(input string name);
        int n = 0;
        while (!b.cpu_ready && n < 200) begin @(negedge clk); n++; end
        chk({name, "_timeout"}, 32'(n < 200), 1);
        @(posedge clk); #1;
    endtask
    task automatic cpu_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        expect_write(a, be, d);
        b.cpu_wr = 1'b1; b.cpu_a = a; b.cpu_be = be; b.cpu_di = d;
        wait_ready("wr");
        b.cpu_wr = 1'b0;
    endtask
    task automatic cpu_read(input logic [AW-1:0] a);
        exp_q.push_back('{rd: 1'b1, data: ref_mem[a[4:0]]});
        b.cpu_rd = 1'b1; b.cpu_a = a;
        wait_ready("rd");
        b.cpu_rd = 1'b0;
    endtask
    task automatic drain(input string name);
        int n = 0;
        while ((wb_count != 0 || b.mem_wr) && n < 500) begin @(negedge clk); n++; end
        chk({name, "_drain_timeout"}, 32'(n < 500), 1);
        @(posedge clk); #1;
    endtask
    initial begin
        b.cpu_rd = 1'b0; b.cpu_wr = 1'b0; b.cpu_a = '0; b.cpu_be = '0; b.cpu_di = '0;
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(wb_count), 0);
        chk("rst_ready", 32'(b.cpu_ready), 0);
        chk("rst_cpu_q", b.cpu_q, 0);
        chk("rst_mem_req", {30'b0, b.mem_rd, b.mem_wr}, 0);
        chk("rst_mem_bus", 32'(b.mem_a) | 32'(b.mem_be) | b.mem_di, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // full-word write on idle buffer, controller stalled so the issue can be observed
        expect_write(19'h10, 4'hf, 32'h11223344);
        b.cpu_wr = 1'b1; b.cpu_a = 19'h10; b.cpu_be = 4'hf; b.cpu_di = 32'h11223344;
        @(negedge clk);
        chk("t2_no_early_ready", 32'(b.cpu_ready), 0);
        @(negedge clk);
        chk("t2_ready", 32'(b.cpu_ready), 1);
        chk("t2_count1", 32'(wb_count), 1);
        @(posedge clk); #1;
        b.cpu_wr = 1'b0;
        @(negedge clk);
        chk("t2_mem_wr", 32'(b.mem_wr), 1);
        chk("t2_mem_a", 32'(b.mem_a), 32'h10);
        chk("t2_mem_be", 32'(b.mem_be), 32'hf);
        chk("t2_mem_di", b.mem_di, 32'h11223344);
        hold = 1'b0;
        drain("t2");
        chk("t2_count0", 32'(wb_count), 0);
        chk("t2_sram", sram[16], 32'h11223344);
        // byte merge behind an in-flight write
        hold = 1'b1;
        wr_log.delete();
        cpu_write(19'h1, 4'hf, 32'hdeadbeef);
        cpu_write(19'h2, 4'b0001, 32'h000000aa);
        cpu_write(19'h2, 4'b0010, 32'h0000bb00);
        @(negedge clk);
        chk("t3_count", 32'(wb_count), 2);
        @(posedge clk); #1;
        hold = 1'b0;
        drain("t3");
        chk("t3_nwr", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) chk("t3_addr", 32'(wr_log[1]), 2);
        chk("t3_be", 32'(last_be), 32'h3);
        chk("t3_di", 32'(last_di[15:0]), 32'hbbaa);
        // push coinciding with pop at count 2
        hold = 1'b1;
        wr_log.delete();
        cpu_write(19'h3, 4'hf, 32'h33333333);
        cpu_write(19'h4, 4'hf, 32'h44444444);
        @(negedge clk);
        chk("t6_count_before", 32'(wb_count), 2);
        kick_req++;
        @(posedge clk); #1;
        expect_write(19'h5, 4'hf, 32'h55555555);
        b.cpu_wr = 1'b1; b.cpu_a = 19'h5; b.cpu_be = 4'hf; b.cpu_di = 32'h55555555;
        @(negedge clk);
        chk("t6_mem_ready", 32'(b.mem_ready), 1);
        @(negedge clk);
        chk("t6_count_push_pop", 32'(wb_count), 2);
        chk("t6_ready", 32'(b.cpu_ready), 1);
        @(posedge clk); #1;
        b.cpu_wr = 1'b0;
        hold = 1'b0;
        drain("t6");
        chk("t6_nwr", 32'(wr_log.size()), 3);
        if (wr_log.size() == 3) chk("t6_order", {8'h0, 8'(wr_log[0]), 8'(wr_log[1]), 8'(wr_log[2])}, 32'h00030405);
        // full buffer stalls the next write until the first drain
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) cpu_write(19'(8 + i), 4'hf, $urandom);
        @(negedge clk);
        chk("t4_full", 32'(wb_count), DEPTH);
        @(posedge clk); #1;
        fork
            cpu_write(19'hc, 4'hf, 32'hcccc0000);
            begin
                int n = 0;
                repeat (8) begin @(negedge clk); chk("t4_stall", 32'(b.cpu_ready), 0); end
                hold = 1'b0;
                while (!b.mem_ready && n < 100) begin @(negedge clk); n++; end
                chk("t4_mr_timeout", 32'(n < 100), 1);
                mr_cyc = cyc;
            end
        join
        chk("t4_ack_latency", 32'(ready_cyc - mr_cyc), 2);
        drain("t4");
        // read waits for queued writes to drain
        hold = 1'b1;
        cpu_write(19'h14, 4'hf, 32'ha0a0a0a0);
        cpu_write(19'h15, 4'hf, 32'hb1b1b1b1);
        cpu_write(19'h16, 4'hf, 32'hc2c2c2c2);
        fork
            cpu_read(19'h15);
            begin
                repeat (4) begin @(negedge clk); chk("t5_rd_waits", 32'(b.mem_rd), 0); end
                hold = 1'b0;
            end
        join
        // randomized traffic over a small address window to provoke merges
        for (int i = 0; i < 200; i++) begin
            int r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            a = 19'($urandom_range(0, 7));
            if (r < 6) cpu_write(a, r < 2 ? 4'hf : 4'($urandom_range(1, 15)), $urandom);
            else cpu_read(a);
        end
        drain("rand");
        for (int i = 0; i < 32; i++) chk("sram_image", sram[i], ref_mem[i]);
        // async reset with a write in flight and three entries queued
        hold = 1'b1;
        cpu_write(19'h18, 4'hf, 32'h18181818);
        cpu_write(19'h19, 4'hf, 32'h19191919);
        cpu_write(19'h1a, 4'hf, 32'h1a1a1a1a);
        @(negedge clk);
        chk("t7_mem_wr_pre", 32'(b.mem_wr), 1);
        chk("t7_count_pre", 32'(wb_count), 3);
        #1 rst = 1'b1;
        #1;
        chk("t7_mem_wr_rst", 32'(b.mem_wr), 0);
        chk("t7_ready_rst", 32'(b.cpu_ready), 0);
        chk("t7_count_rst", 32'(wb_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = sram[i];
        hold = 1'b0;
        cpu_write(19'h1b, 4'hf, 32'h1b1b1b1b);
        drain("t7");
        chk("t7_sram", sram[27], 32'h1b1b1b1b);
        cpu_read(19'h18);
        cpu_read(19'h1b);
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
